// File: rtl/nco_cnt_mod_if.sv
// Control and status bundle for nco_cnt_mod: NCO period, run/dir/clear/load
// controls, and the count, pulse and BCD outputs.
interface nco_cnt_mod_if #(
    parameter int CNT_W = 6,
    parameter int NCO_W = 32
);
    logic [NCO_W-1:0] i_nco_num;
    logic             i_run;
    logic             i_dir;
    logic             i_clear;
    logic             i_load;
    logic [CNT_W-1:0] i_load_val;
    logic [CNT_W-1:0] o_cnt;
    logic             o_tick;
    logic             o_carry;
    logic [3:0]       o_tens;
    logic [3:0]       o_units;

    modport master (
        output i_nco_num, i_run, i_dir, i_clear, i_load, i_load_val,
        input  o_cnt, o_tick, o_carry, o_tens, o_units
    );

    modport slave (
        input  i_nco_num, i_run, i_dir, i_clear, i_load, i_load_val,
        output o_cnt, o_tick, o_carry, o_tens, o_units
    );
endinterface

// File: rtl/nco_cnt_mod.sv
// Modulo-MOD up/down counter stepped by an internal NCO tick on a single clock,
// with clear/load, registered tick/carry pulses and a BCD tens/units split.
module nco_cnt_mod #(
    parameter int CNT_W = 6,
    parameter int MOD   = 60,
    parameter int NCO_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    nco_cnt_mod_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOD - 1);
    localparam logic [CNT_W:0]   MOD_EXT = (CNT_W + 1)'(MOD);

    logic [NCO_W-1:0] nco_q;
    logic [NCO_W-1:0] period;
    logic             nco_wrap;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] load_clamped;
    logic             tick_q;
    logic             carry_q;
    logic [3:0]       tens;
    logic [3:0]       units;

    assign period   = (bus.i_nco_num == '0) ? NCO_W'(1) : bus.i_nco_num;
    // >= rather than == so a period lowered below nco_q steps at once instead of locking up
    assign nco_wrap = bus.i_run && (nco_q >= period - NCO_W'(1));

    assign load_clamped = ({1'b0, bus.i_load_val} >= MOD_EXT) ? CNT_MAX : bus.i_load_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nco_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (bus.i_clear) begin
            nco_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            if (!bus.i_run || nco_wrap) begin
                nco_q <= '0;
            end else begin
                nco_q <= nco_q + NCO_W'(1);
            end
            // load keeps the NCO running but swallows any step in the same cycle
            if (bus.i_load) begin
                cnt_q <= load_clamped;
            end else if (nco_wrap) begin
                tick_q <= 1'b1;
                if (!bus.i_dir) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        carry_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CNT_MAX;
                        carry_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        int unsigned v;
        v     = 32'(cnt_q);
        tens  = 4'(v / 10);
        units = 4'(v % 10);
    end

    assign bus.o_cnt   = cnt_q;
    assign bus.o_tick  = tick_q;
    assign bus.o_carry = carry_q;
    assign bus.o_tens  = tens;
    assign bus.o_units = units;
endmodule
